fetch_stage: RTL and testbench

//  Instruction fetch stage. It is the producer side of the decode interface: it drives the

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 13 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_stage.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, instruction word and
// the prefetch buffer entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef logic [15:0] instr_t;

    localparam instr_t NOP_INSTR = 16'h000F;

    typedef struct packed {
        instr_t      instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory bus: pipelined request/grant with in-order rvalid responses.
interface fetch_if;
    import fetch_pkg::*;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    instr_t      rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer for fetched {instr, pc} entries; flush wins over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           wdata_i,
    input  logic                   pop_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_i && !pop_i) begin
                count_d = count_q + (PW+1)'(1);
            end else if (!push_i && pop_i) begin
                count_d = count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding decode from a pipelined imem bus.
// Optional FETCH_PERF_CNT_EN adds fetched/stall/flush performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    fetch_if.master     imem,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        end_program_i,
    output instr_t      instr_o,
    output logic        instr_en_o,
    output logic [31:0] programm_counter_o,
    output logic [31:0] next_programm_counter_o,
    output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`endif
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    instr_t        instr_q, instr_d;
    logic          instr_en_q, instr_en_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   npc_q, npc_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;
    fetch_entry_t  fifo_wdata, fifo_rdata, out_entry;
    logic          req, grant, rsp_keep, branch_take, halting, pop_valid;
    logic [CW:0]   occupancy;

    always_comb begin
        halting     = end_program_i || (state_q == HALT);
        branch_take = branch_i && !halting;
        occupancy   = {1'b0, outst_q} + {1'b0, fifo_count};
        req         = ((state_q == RUN) || (state_q == FLUSH)) && !branch_i
                      && (occupancy < (CW+1)'(FIFO_DEPTH));
        grant       = req && imem.gnt;
        rsp_keep    = imem.rvalid && (discard_q == '0) && !halting && !branch_take;
        fifo_wdata  = '{instr: imem.rdata, pc: resp_pc_q};
        fifo_flush  = branch_take || halting;

        // An empty buffer lets a fresh response go straight to the decode register.
        fifo_push  = rsp_keep;
        fifo_pop   = 1'b0;
        pop_valid  = 1'b0;
        out_entry  = fifo_rdata;
        instr_d    = instr_q;
        instr_en_d = instr_en_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        if (halting || branch_take) begin
            instr_en_d = 1'b0;
            instr_d    = NOP_INSTR;
        end else if (!stall_i) begin
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                pop_valid = 1'b1;
            end else if (rsp_keep) begin
                fifo_push = 1'b0;
                pop_valid = 1'b1;
                out_entry = fifo_wdata;
            end
            if (pop_valid) begin
                instr_en_d = 1'b1;
                instr_d    = out_entry.instr;
                pc_d       = out_entry.pc;
                npc_d      = out_entry.pc + 32'd2;
            end else begin
                instr_en_d = 1'b0;
                instr_d    = NOP_INSTR;
            end
        end

        outst_d = outst_q;
        if (grant && !imem.rvalid) begin
            outst_d = outst_q + CW'(1);
        end else if (!grant && imem.rvalid) begin
            outst_d = outst_q - CW'(1);
        end

        // Every request still in flight at a branch belongs to the old path.
        discard_d = discard_q;
        if (branch_take) begin
            discard_d = outst_q - (imem.rvalid ? CW'(1) : '0);
        end else if (imem.rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        resp_pc_d  = resp_pc_q;
        fetch_pc_d = fetch_pc_q;
        if (branch_take) begin
            resp_pc_d  = branch_target_i & ~32'h1;
            fetch_pc_d = branch_target_i & ~32'h1;
        end else begin
            if (rsp_keep) resp_pc_d = resp_pc_q + 32'd2;
            if (grant) fetch_pc_d = fetch_pc_q + 32'd2;
        end

        state_d = state_q;
        if (end_program_i) begin
            state_d = HALT;
        end else begin
            case (state_q)
                BOOT:  state_d = RUN;
                RUN:   if (branch_take && (outst_q != '0)) state_d = FLUSH;
                FLUSH: if (!(branch_take && (outst_q != '0)) && (discard_d == '0)) state_d = RUN;
                HALT:  state_d = HALT;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            instr_q    <= NOP_INSTR;
            instr_en_q <= 1'b0;
            pc_q       <= '0;
            npc_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            instr_en_q <= instr_en_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fifo_push && fifo_full && !fifo_flush && !fifo_pop));

    assign imem.req                = req;
    assign imem.addr               = fetch_pc_q;
    assign instr_o                 = instr_q;
    assign instr_en_o              = instr_en_q;
    assign programm_counter_o      = pc_q;
    assign next_programm_counter_o = npc_q;
    assign halted_o                = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop_valid);
        perf_stall_d   = perf_stall_q + 32'(stall_i && !fifo_empty);
        perf_flush_d   = perf_flush_q + 32'(branch_take);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stall_o   = perf_stall_q;
    assign perf_flush_o   = perf_flush_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: program-order PC model, memory responder, output monitor.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] target = '0;
    logic        end_prog = 1'b0;
    instr_t      instr;
    logic        instr_en;
    logic [31:0] pc, npc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

    fetch_if imem_bus ();

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .imem                    (imem_bus),
        .stall_i                 (stall),
        .branch_i                (branch),
        .branch_target_i         (target),
        .end_program_i           (end_prog),
        .instr_o                 (instr),
        .instr_en_o              (instr_en),
        .programm_counter_o      (pc),
        .next_programm_counter_o (npc),
        .halted_o                (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o          (perf_fetched),
        .perf_stall_o            (perf_stall),
        .perf_flush_o            (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct { logic [31:0] pc; instr_t instr; } exp_t;
    typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] model_pc = RST_PC;
    bit          model_halted = 1'b0;
    int          mem_mode = 0;

    function automatic instr_t mem_word(input logic [31:0] a);
        return a[15:0];
    endfunction

    // Memory responder and program-order model: each accepted request must be the next PC.
    initial begin
        int unsigned cyc = 0;
        int unsigned lat;
        bit g, rv;
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = '0;
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (!rst_n) begin
                pend_q.delete();
                exp_q.delete();
                model_pc        = RST_PC;
                model_halted    = 1'b0;
                imem_bus.gnt    = 1'b0;
                imem_bus.rvalid = 1'b0;
                continue;
            end
            if (end_prog) begin
                model_halted = 1'b1;
                exp_q.delete();
            end else if (branch && !model_halted) begin
                exp_q.delete();
                model_pc = target & ~32'h1;
            end
            case (mem_mode)
                0:       begin g = 1'b1; lat = 0; end
                1:       begin g = 1'b1; lat = 2; end
                2:       begin g = ($urandom_range(0, 3) != 0); lat = $urandom_range(0, 3); end
                default: begin g = (pend_q.size() == 0); lat = 3; end
            endcase
            imem_bus.gnt = g;
            if (imem_bus.req && g) begin
                check("req_addr", imem_bus.addr, model_pc);
                exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
                pend_q.push_back('{addr: model_pc, due: cyc + 1 + lat});
                model_pc = model_pc + 32'd2;
                check("outstanding_cap", 32'(pend_q.size() <= DEPTH), 32'd1);
            end
            rv = (pend_q.size() > 0) && (pend_q[0].due <= cyc)
                 && ((mem_mode != 2) || ($urandom_range(0, 3) != 0));
            if (rv) begin
                imem_bus.rvalid = 1'b1;
                imem_bus.rdata  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_bus.rvalid = 1'b0;
                imem_bus.rdata  = instr_t'($urandom);
            end
        end
    end

    // Monitor: compares each presented instruction against the expected program order.
    initial begin
        exp_t e, last;
        bit   last_en = 1'b0;
        last = '{pc: '0, instr: NOP_INSTR};
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last_en = 1'b0;
            end else if (model_halted) begin
                check("halted_flag", 32'(halted), 32'd1);
                check("halt_instr_en", 32'(instr_en), 32'd0);
                check("halt_req", 32'(imem_bus.req), 32'd0);
                last_en = 1'b0;
            end else if (branch) begin
                check("branch_bubble", 32'(instr_en), 32'd0);
                last_en = 1'b0;
            end else if (stall) begin
                check("stall_hold_en", 32'(instr_en), 32'(last_en));
                if (last_en) begin
                    check("stall_hold_pc", pc, last.pc);
                    check("stall_hold_instr", 32'(instr), 32'(last.instr));
                end
            end else if (instr_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_instr_en", 32'(instr_en), 32'd0);
                    last_en = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("pc", pc, e.pc);
                    check("instr", 32'(instr), 32'(e.instr));
                    check("next_pc", npc, e.pc + 32'd2);
                    last    = e;
                    last_en = 1'b1;
                end
            end else begin
                last_en = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_bus.req), 32'd0);
        check({tag, "_addr"}, imem_bus.addr, RST_PC);
        check({tag, "_instr"}, 32'(instr), 32'h0000_000F);
        check({tag, "_instr_en"}, 32'(instr_en), 32'd0);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_npc"}, npc, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic wait_outstanding(input int n, input string name);
        int k = 0;
        while ((pend_q.size() != n) && (k < 30)) begin
            step();
            k++;
        end
        check(name, 32'(pend_q.size()), 32'(n));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Zero-wait memory: continuous stream once the pipe has filled.
        mem_mode = 0;
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("stream_en", 32'(instr_en), 32'd1);
        end

        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        repeat (6) step();

        // Branch to an odd target with two responses in flight.
        mem_mode = 1;
        wait_outstanding(2, "two_outstanding");
        branch = 1'b1;
        target = 32'h0000_0101;
        step();
        branch = 1'b0;
        repeat (10) step();

        // Branch and stall together.
        mem_mode = 0;
        stall  = 1'b1;
        branch = 1'b1;
        target = 32'h0000_0240;
        step();
        branch = 1'b0;
        repeat (2) step();
        stall = 1'b0;
        repeat (6) step();

        // Address wrap at the top of the address space.
        branch = 1'b1;
        target = 32'hFFFF_FFFC;
        step();
        branch = 1'b0;
        repeat (8) step();

        mem_mode = 2;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                branch = 1'b1;
                if ($urandom_range(0, 7) == 0) target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else target = 32'($urandom_range(0, 4095));
            end else begin
                branch = 1'b0;
            end
            step();
        end
        branch = 1'b0;
        stall  = 1'b0;
        repeat (10) step();

        // Halt with one response outstanding, then an asynchronous reset mid-cycle.
        mem_mode = 3;
        wait_outstanding(1, "one_outstanding");
        end_prog = 1'b1;
        step();
        end_prog = 1'b0;
        repeat (6) step();
        check("halted_after_drain", 32'(halted), 32'd1);

        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        step();
        rst_n = 1'b1;
        mem_mode = 0;
        repeat (12) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
